// File: rtl/tx_bit_stream.sv
// Bit-error test link transmitter: preamble, sync word, then FRAMES copies of a UART-loaded pattern.
// Define TX_PREAMBLE_EN to include the alternating preamble ahead of the sync word.
module tx_bit_stream #(
    parameter int unsigned          PATTERN_W    = 32,
    parameter logic [PATTERN_W-1:0] PATTERN_INIT = 32'hDEAD_BEEF,
    parameter int unsigned          SYNC_W       = 16,
    parameter logic [SYNC_W-1:0]    SYNC_WORD    = 16'hF0A5,
    parameter int unsigned          PRE_LEN      = 64,
    parameter int unsigned          FRAMES       = 281250
) (
    input  logic        clk9MHz,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_data,
    output logic        tx_bit_data,
    output logic        tx_active,
    output logic        tx_done,
    output logic [23:0] frame_cnt,
    output logic        cfg_pending
);
    localparam int unsigned BYTES   = PATTERN_W / 8;
    localparam int unsigned BC_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned FRM_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned SR_W    = (SYNC_W > PATTERN_W) ? SYNC_W : PATTERN_W;
    localparam int unsigned CNT_MAX = (PRE_LEN > SR_W) ? PRE_LEN : SR_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef TX_PREAMBLE_EN
        S_PRE,
`endif
        S_SYNC,
        S_DATA,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRM_W-1:0]       frm_q, frm_d;
    logic [SR_W-1:0]        sr_q, sr_d;
    logic [PATTERN_W-1:0]   active_q, active_d;
    logic [PATTERN_W-1:0]   shadow_q, shadow_d;
    logic [BC_W-1:0]        byte_q, byte_d;
    logic                   pend_q, pend_d;
    logic                   bit_q, bit_d;
    logic                   act_q, act_d;
    logic                   done_q, done_d;
    logic [23:0]            fcnt_q, fcnt_d;
    logic                   frame_commit;
    logic [PATTERN_W-1:0]   next_pat;
    logic [SR_W-1:0]        sync_load;

    // Shift register holds the not-yet-sent bits left-aligned; MSB is the next bit out.
    assign sync_load = {SYNC_WORD[SYNC_W-2:0], {(SR_W-SYNC_W+1){1'b0}}};
    assign next_pat  = pend_q ? shadow_q : active_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frm_d        = frm_q;
        sr_d         = {sr_q[SR_W-2:0], 1'b0};
        fcnt_d       = fcnt_q;
        bit_d        = 1'b0;
        act_d        = 1'b0;
        done_d       = 1'b0;
        frame_commit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    fcnt_d = '0;
                    frm_d  = '0;
                    cnt_d  = '0;
                    act_d  = 1'b1;
`ifdef TX_PREAMBLE_EN
                    state_d = S_PRE;
                    bit_d   = 1'b1;
`else
                    state_d = S_SYNC;
                    bit_d   = SYNC_WORD[SYNC_W-1];
                    sr_d    = sync_load;
`endif
                end
            end
`ifdef TX_PREAMBLE_EN
            S_PRE: begin
                act_d = 1'b1;
                if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    bit_d   = SYNC_WORD[SYNC_W-1];
                    sr_d    = sync_load;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    bit_d = cnt_q[0];
                end
            end
`endif
            S_SYNC: begin
                act_d = 1'b1;
                if (cnt_q == CNT_W'(SYNC_W - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    frm_d   = '0;
                    bit_d   = active_q[PATTERN_W-1];
                    sr_d    = {active_q[PATTERN_W-2:0], {(SR_W-PATTERN_W+1){1'b0}}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    bit_d = sr_q[SR_W-1];
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(PATTERN_W - 1)) begin
                    if (frm_q == FRM_W'(FRAMES - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Frame boundary: the only in-burst point where a pending pattern may take over.
                        act_d        = 1'b1;
                        cnt_d        = '0;
                        frm_d        = frm_q + FRM_W'(1);
                        frame_commit = pend_q;
                        bit_d        = next_pat[PATTERN_W-1];
                        sr_d         = {next_pat[PATTERN_W-2:0], {(SR_W-PATTERN_W+1){1'b0}}};
                    end
                end else begin
                    act_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    bit_d = sr_q[SR_W-1];
                    if (cnt_q == CNT_W'(PATTERN_W - 2) && fcnt_q != '1) begin
                        fcnt_d = fcnt_q + 24'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            bit_d        = 1'b0;
            act_d        = 1'b0;
            done_d       = 1'b0;
            fcnt_d       = fcnt_q;
            frame_commit = 1'b0;
        end
    end

    // Pattern loading and commit; a byte completing the pattern wins over a same-cycle commit.
    always_comb begin
        active_d = active_q;
        shadow_d = shadow_q;
        byte_d   = byte_q;
        pend_d   = pend_q;
        if (pend_q && (state_q == S_IDLE || frame_commit)) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (cfg_valid) begin
            shadow_d = (shadow_q << 8) | PATTERN_W'(cfg_data);
            if (byte_q == BC_W'(BYTES - 1)) begin
                byte_d = '0;
                pend_d = 1'b1;
            end else begin
                byte_d = byte_q + BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk9MHz or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            frm_q    <= '0;
            sr_q     <= '0;
            active_q <= PATTERN_INIT;
            shadow_q <= '0;
            byte_q   <= '0;
            pend_q   <= 1'b0;
            bit_q    <= 1'b0;
            act_q    <= 1'b0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frm_q    <= frm_d;
            sr_q     <= sr_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            byte_q   <= byte_d;
            pend_q   <= pend_d;
            bit_q    <= bit_d;
            act_q    <= act_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign tx_bit_data = bit_q;
    assign tx_active   = act_q;
    assign tx_done     = done_q;
    assign frame_cnt   = fcnt_q;
    assign cfg_pending = pend_q;
endmodule

// File: tb/tb_tx_bit_stream.sv
// Self-checking bench for tx_bit_stream: bit-position reference model plus per-scenario checks.
module tb_tx_bit_stream;
    localparam int PW = 32;
    localparam int SW = 16;
    localparam int PL = 64;
    localparam int NF = 3;
`ifdef TX_PREAMBLE_EN
    localparam int PRE = PL;
`else
    localparam int PRE = 0;
`endif
    localparam int BURST = PRE + SW + NF * PW;
    localparam logic [31:0] P_INIT = 32'hDEAD_BEEF;

    logic        clk9MHz = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        tx_bit_data, tx_active, tx_done, cfg_pending;
    logic [23:0] frame_cnt;
    logic [27:0] obs;
    logic [15:0] sync_word = 16'hF0A5;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: position within the burst (-1 idle, -2 completion cycle)
    int          m_pos;
    logic [31:0] m_active, m_shadow, m_cur;
    int          m_bytes;
    logic        m_pend, m_bit;
    logic [23:0] m_fcnt;
    logic [31:0] last_pat;
    logic [31:0] got [NF];

    tx_bit_stream #(
        .PATTERN_W(PW), .PATTERN_INIT(P_INIT), .SYNC_W(SW), .SYNC_WORD(16'hF0A5),
        .PRE_LEN(PL), .FRAMES(NF)
    ) dut (
        .clk9MHz(clk9MHz), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .tx_bit_data(tx_bit_data),
        .tx_active(tx_active), .tx_done(tx_done), .frame_cnt(frame_cnt),
        .cfg_pending(cfg_pending)
    );

    always #5 clk9MHz = ~clk9MHz;

    assign obs = {tx_bit_data, tx_active, tx_done, cfg_pending, frame_cnt};

    function automatic logic [27:0] exp_vec();
        return {m_bit, m_pos >= 0, m_pos == -2, m_pend, m_fcnt};
    endfunction

    task automatic model_reset();
        m_pos = -1; m_active = P_INIT; m_shadow = '0; m_cur = '0;
        m_bytes = 0; m_pend = 1'b0; m_bit = 1'b0; m_fcnt = '0;
    endtask

    task automatic model_step(input logic s, input logic st, input logic cv, input logic [7:0] cd);
        logic commit;
        int   d;
        d = m_pos - PRE - SW;
        commit = m_pend && (m_pos == -1 ||
                 (m_pos >= PRE + SW && d % PW == PW - 1 && d / PW < NF - 1 && !st));
        if (st && m_pos != -1)        m_pos = -1;
        else if (m_pos == -1)         begin if (s && !st) begin m_pos = 0; m_fcnt = '0; end end
        else if (m_pos == -2)         m_pos = -1;
        else if (m_pos == BURST - 1)  m_pos = -2;
        else                          m_pos++;
        m_bit = 1'b0;
        if (m_pos >= 0) begin
            if (m_pos < PRE) m_bit = (m_pos % 2 == 0);
            else if (m_pos < PRE + SW) m_bit = sync_word[SW - 1 - (m_pos - PRE)];
            else begin
                d = m_pos - PRE - SW;
                if (d % PW == 0) m_cur = (d == 0) ? m_active : (commit ? m_shadow : m_active);
                m_bit = m_cur[PW - 1 - d % PW];
                if (d % PW == PW - 1 && m_fcnt != 24'hFF_FFFF) m_fcnt++;
            end
        end
        if (commit) begin m_active = m_shadow; m_pend = 1'b0; end
        if (cv) begin
            m_shadow = {m_shadow[23:0], cd};
            m_bytes++;
            if (m_bytes == PW / 8) begin m_bytes = 0; m_pend = 1'b1; end
        end
    endtask

    task automatic cyc(input logic s, input logic st, input logic cv, input logic [7:0] cd);
        start = s; stop = st; cfg_valid = cv; cfg_data = cd;
        model_step(s, st, cv, cd);
        @(posedge clk9MHz); #1;
    endtask

    task automatic capture(input int k);
        int idx;
        if (k >= PRE + SW + 1 && k <= BURST) begin
            idx = k - PRE - SW - 1;
            got[idx / PW][PW - 1 - idx % PW] = tx_bit_data;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk9MHz);
        #1;
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_vec());
        end
        rst = 1'b1;
        cyc(0, 0, 0, 8'h00);
    endtask

    task automatic test_default_burst();
        int done_at = -1, done_n = 0;
        for (int k = 0; k <= BURST + 3; k++) begin
            if (k > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL default_burst cyc %0d: got %h expected %h", k, obs, exp_vec());
                end
                if (tx_done === 1'b1) begin done_n++; if (done_at < 0) done_at = k; end
                capture(k);
            end
            cyc(k == 0, 0, 0, 8'h00);
        end
        n_checks++;
        if (done_at != BURST + 1 || done_n != 1) begin
            n_fails++;
            $display("FAIL done_timing: got cycle %0d x%0d expected cycle %0d x1", done_at, done_n, BURST + 1);
        end
        n_checks++;
        if (frame_cnt !== 24'(NF)) begin
            n_fails++;
            $display("FAIL frame_cnt_end: got %0d expected %0d", frame_cnt, NF);
        end
        for (int f = 0; f < NF; f++) begin
            n_checks++;
            if (got[f] !== P_INIT) begin
                n_fails++;
                $display("FAIL default_frame%0d: got %h expected %h", f, got[f], P_INIT);
            end
        end
    endtask

    task automatic test_idle_load();
        logic [7:0] b [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int pend_n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, b[i]);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL idle_load byte %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (cfg_pending === 1'b1) pend_n++;
            repeat ($urandom_range(0, 2)) begin
                cyc(0, 0, 0, 8'h00);
                if (cfg_pending === 1'b1) pend_n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 8'h00);
            if (cfg_pending === 1'b1) pend_n++;
        end
        n_checks++;
        if (pend_n != 1) begin
            n_fails++;
            $display("FAIL pending_width: got %0d cycles expected 1", pend_n);
        end
        for (int k = 0; k <= BURST + 2; k++) begin
            if (k > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL idle_load_burst cyc %0d: got %h expected %h", k, obs, exp_vec());
                end
                capture(k);
            end
            cyc(k == 0, 0, 0, 8'h00);
        end
        for (int f = 0; f < NF; f++) begin
            n_checks++;
            if (got[f] !== 32'h1234_5678) begin
                n_fails++;
                $display("FAIL idle_load_frame%0d: got %h expected 12345678", f, got[f]);
            end
        end
        last_pat = 32'h1234_5678;
    endtask

    task automatic test_midburst_load(input logic on_boundary);
        logic [31:0] newp, tmp, expf;
        int kb;
        newp = $urandom;
        kb = on_boundary ? (PRE + SW + PW - 3) : int'($urandom_range(2, PRE + SW + PW - 4));
        for (int k = 0; k <= BURST + 2; k++) begin
            if (k > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL midburst_load b%0d cyc %0d: got %h expected %h", on_boundary, k, obs, exp_vec());
                end
                capture(k);
            end
            if (k >= kb && k < kb + 4) begin
                tmp = newp << (8 * (k - kb));
                cyc(k == 0, 0, 1, tmp[31:24]);
            end else begin
                cyc(k == 0, 0, 0, 8'h00);
            end
        end
        for (int f = 0; f < NF; f++) begin
            expf = (f == 0 || (on_boundary && f == 1)) ? last_pat : newp;
            n_checks++;
            if (got[f] !== expf) begin
                n_fails++;
                $display("FAIL midburst_frame%0d b%0d: got %h expected %h", f, on_boundary, got[f], expf);
            end
        end
        last_pat = newp;
    endtask

    task automatic test_stop();
        int ks, done_n = 0;
        ks = PRE + 1 + int'($urandom_range(0, SW - 1));
        for (int k = 0; k <= ks + 6; k++) begin
            if (k > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL stop_sync cyc %0d: got %h expected %h", k, obs, exp_vec());
                end
                if (tx_done === 1'b1) done_n++;
                if (k == ks + 1) begin
                    n_checks++;
                    if ({tx_active, tx_bit_data} !== 2'b00) begin
                        n_fails++;
                        $display("FAIL stop_outputs: got %b expected 00", {tx_active, tx_bit_data});
                    end
                end
            end
            cyc(k == 0 || k == 3, k == ks, 0, 8'h00);
        end
        n_checks++;
        if (done_n != 0) begin
            n_fails++;
            $display("FAIL stop_no_done: got %0d pulses expected 0", done_n);
        end
        cyc(1, 1, 0, 8'h00);
        n_checks++;
        if (tx_active !== 1'b0) begin
            n_fails++;
            $display("FAIL stop_beats_start: got tx_active %b expected 0", tx_active);
        end
        cyc(0, 0, 0, 8'h00);
    endtask

    task automatic test_rst_mid();
        int kr;
        kr = PRE + SW + 5 + int'($urandom_range(0, PW));
        for (int k = 0; k < kr; k++) cyc(k == 0, 0, k == 4, 8'hA5);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 28'h0) begin
            n_fails++;
            $display("FAIL async_reset: got %h expected 0000000", obs);
        end
        model_reset();
        #2 rst = 1'b1;
        @(posedge clk9MHz); #1;
        for (int k = 0; k <= BURST + 2; k++) begin
            if (k > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL post_reset_burst cyc %0d: got %h expected %h", k, obs, exp_vec());
                end
                capture(k);
            end
            cyc(k == 0, 0, 0, 8'h00);
        end
        for (int f = 0; f < NF; f++) begin
            n_checks++;
            if (got[f] !== P_INIT) begin
                n_fails++;
                $display("FAIL post_reset_frame%0d: got %h expected %h", f, got[f], P_INIT);
            end
        end
    endtask

    task automatic test_random();
        logic s, st, cv;
        for (int k = 0; k < 1500; k++) begin
            s  = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 299) == 0);
            cv = ($urandom_range(0, 5) == 0);
            cyc(s, st, cv, 8'($urandom));
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL random cyc %0d: got %h expected %h", k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        last_pat = P_INIT;
        test_reset();
        test_default_burst();
        test_idle_load();
        test_midburst_load(1'b0);
        test_midburst_load(1'b1);
        test_stop();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
